// File: rtl/compute_s.sv
// compute_s: second-pass IDCT, S = C^T * T for one 8x8 block using a single sequential MAC.
// Optional macro CS_ROUND_EN rounds the >>>8 result half-up instead of truncating.
module compute_s (
    input  logic               CLOCK_50_I,
    input  logic               Resetn,
    input  logic               CS_start,
    output logic               CS_done,
    output logic [6:0]         T_read_address,
    input  logic signed [31:0] T_read_data,
    output logic [6:0]         S_write_address,
    output logic signed [31:0] S_write_data,
    output logic               S_write_enable
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2} state_t;
    // Flattened C[k][i], row k at offset 8*k
    localparam logic signed [15:0] C_ROM [64] = '{
        16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,
        16'sd2008,  16'sd1702,  16'sd1137,  16'sd399,  -16'sd399,  -16'sd1137, -16'sd1702, -16'sd2008,
        16'sd1892,  16'sd783,  -16'sd783,  -16'sd1892, -16'sd1892, -16'sd783,   16'sd783,   16'sd1892,
        16'sd1702, -16'sd399,  -16'sd2008, -16'sd1137,  16'sd1137,  16'sd2008,  16'sd399,  -16'sd1702,
        16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,
        16'sd1137, -16'sd2008,  16'sd399,   16'sd1702, -16'sd1702, -16'sd399,   16'sd2008, -16'sd1137,
        16'sd783,  -16'sd1892,  16'sd1892, -16'sd783,  -16'sd783,   16'sd1892, -16'sd1892,  16'sd783,
        16'sd399,  -16'sd1137,  16'sd1702, -16'sd2008,  16'sd2008, -16'sd1702,  16'sd1137, -16'sd399
    };
`ifdef CS_ROUND_EN
    localparam logic signed [47:0] RND = 48'sd128;
`else
    localparam logic signed [47:0] RND = 48'sd0;
`endif
    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [2:0]         i_dly_q, i_dly_d, j_dly_q, j_dly_d, k_dly_q, k_dly_d;
    logic               vld_q, vld_d;
    logic signed [47:0] acc_q, acc_d, prod, sum;
    logic signed [15:0] coef;
    logic [6:0]         waddr_d;
    logic signed [31:0] wdata_d;
    logic               we_d, done_d;
    assign T_read_address = (state_q == S_RUN) ? {1'b0, cnt_q[2:0], cnt_q[5:3]} : 7'd0;
    assign coef = C_ROM[{k_dly_q, i_dly_q}];
    assign prod = 48'(T_read_data) * 48'(coef);
    assign sum  = (k_dly_q == 3'd0 ? 48'sd0 : acc_q) + prod;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = CS_start ? S_RUN : S_IDLE;
                cnt_d   = 9'd0;
            end
            S_RUN: begin
                cnt_d   = cnt_q + 9'd1;
                state_d = (cnt_q == 9'd511) ? S_DRAIN1 : S_RUN;
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        endcase
        i_dly_d = cnt_q[8:6];
        j_dly_d = cnt_q[5:3];
        k_dly_d = cnt_q[2:0];
        vld_d   = (state_q == S_RUN);
        acc_d   = vld_q ? sum : acc_q;
        we_d    = vld_q && (k_dly_q == 3'd7);
        waddr_d = we_d ? {1'b0, i_dly_q, j_dly_q} : S_write_address;
        wdata_d = we_d ? 32'((sum + RND) >>> 8) : S_write_data;
    end
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q         <= S_IDLE;
            cnt_q           <= 9'd0;
            i_dly_q         <= 3'd0;
            j_dly_q         <= 3'd0;
            k_dly_q         <= 3'd0;
            vld_q           <= 1'b0;
            acc_q           <= 48'sd0;
            S_write_address <= 7'd0;
            S_write_data    <= 32'sd0;
            S_write_enable  <= 1'b0;
            CS_done         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            i_dly_q         <= i_dly_d;
            j_dly_q         <= j_dly_d;
            k_dly_q         <= k_dly_d;
            vld_q           <= vld_d;
            acc_q           <= acc_d;
            S_write_address <= waddr_d;
            S_write_data    <= wdata_d;
            S_write_enable  <= we_d;
            CS_done         <= done_d;
        end
    end
endmodule

// File: tb/tb_compute_s.sv
// tb_compute_s: scoreboard bench for compute_s with a 1-cycle-latency T RAM model.
module tb_compute_s;
    logic               CLOCK_50_I = 1'b0;
    logic               Resetn = 1'b0;
    logic               CS_start = 1'b0;
    logic               CS_done;
    logic [6:0]         T_read_address;
    logic signed [31:0] T_read_data;
    logic [6:0]         S_write_address;
    logic signed [31:0] S_write_data;
    logic               S_write_enable;
    typedef struct { logic [6:0] a; logic signed [31:0] d; } exp_t;
    exp_t               q[$];
    logic signed [31:0] tmem [64];
    logic signed [31:0] smem [64];
    int checks = 0, errors = 0, cyc = 0;
    int ctab [8][8] = '{
        '{1448, 1448, 1448, 1448, 1448, 1448, 1448, 1448},
        '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008},
        '{1892, 783, -783, -1892, -1892, -783, 783, 1892},
        '{1702, -399, -2008, -1137, 1137, 2008, 399, -1702},
        '{1448, -1448, -1448, 1448, 1448, -1448, -1448, 1448},
        '{1137, -2008, 399, 1702, -1702, -399, 2008, -1137},
        '{783, -1892, 1892, -783, -783, 1892, -1892, 783},
        '{399, -1137, 1702, -2008, 2008, -1702, 1137, -399}
    };
`ifdef CS_ROUND_EN
    localparam int ONE_EXP = 6;
`else
    localparam int ONE_EXP = 5;
`endif

    compute_s dut (
        .CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .CS_start(CS_start), .CS_done(CS_done),
        .T_read_address(T_read_address), .T_read_data(T_read_data),
        .S_write_address(S_write_address), .S_write_data(S_write_data),
        .S_write_enable(S_write_enable)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;
    always @(posedge CLOCK_50_I) begin
        cyc <= cyc + 1;
        T_read_data <= tmem[T_read_address[5:0]];
    end

    function automatic logic signed [31:0] model_s(input int i, input int j);
        longint acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(ctab[k][i]) * longint'(tmem[k*8+j]);
`ifdef CS_ROUND_EN
        acc += 128;
`endif
        acc = acc >>> 8;
        return 32'(acc);
    endfunction

    task automatic clear_t();
        for (int a = 0; a < 64; a++) tmem[a] = 32'sd0;
    endtask

    // Starts nb blocks; optional start pulse during RUN at cycle pulse_at, optional reset at cycle rst_at
    task automatic run_blocks(input int nb, input bit hold, input int pulse_at, input int rst_at);
        int t0, nw, blk, n, exp_n;
        exp_t e;
        nw = 0; blk = 0;
        for (int b = 0; b < nb; b++)
            for (int a = 0; a < 64; a++) q.push_back('{7'(a), model_s(a / 8, a % 8)});
        CS_start = 1'b1;
        t0 = cyc;
        @(posedge CLOCK_50_I); #1;
        if (!hold) CS_start = 1'b0;
        for (int c = 0; c < 520 * nb && blk < nb; c++) begin
            @(negedge CLOCK_50_I);
            n = cyc - t0;
            if (n == pulse_at) CS_start = 1'b1;
            else if (!hold) CS_start = 1'b0;
            if (n == rst_at) begin
                Resetn = 1'b0;
                #1;
                checks++;
                if (CS_done !== 1'b0 || S_write_enable !== 1'b0 || S_write_data !== 32'sd0 ||
                    S_write_address !== 7'd0 || T_read_address !== 7'd0) begin
                    errors++;
                    $display("FAIL reset_mid: done=%0b we=%0b data=%0d waddr=%0d taddr=%0d, required all 0",
                             CS_done, S_write_enable, S_write_data, S_write_address, T_read_address);
                end
                q.delete();
                break;
            end
            if (S_write_enable) begin
                checks++;
                exp_n = 10 + 8 * (nw % 64) + 515 * (nw / 64);
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL write_extra: unexpected write addr=%0d at cycle %0d", S_write_address, n);
                end else begin
                    e = q.pop_front();
                    if (S_write_address !== e.a || S_write_data !== e.d || n != exp_n) begin
                        errors++;
                        $display("FAIL write%0d: addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                                 nw, S_write_address, S_write_data, n, e.a, e.d, exp_n);
                    end
                end
                smem[S_write_address[5:0]] = S_write_data;
                nw++;
            end
            if (CS_done) begin
                checks++;
                if (n != 515 * (blk + 1)) begin
                    errors++;
                    $display("FAIL done_cycle: got cycle %0d, required %0d", n, 515 * (blk + 1));
                end
                blk++;
                if (blk == nb) CS_start = 1'b0;
            end
        end
        if (rst_at < 0) begin
            checks++;
            if (nw != 64 * nb || blk != nb) begin
                errors++;
                $display("FAIL block_count: writes=%0d dones=%0d, required writes=%0d dones=%0d", nw, blk, 64 * nb, nb);
            end
            @(negedge CLOCK_50_I);
            checks++;
            if (CS_done !== 1'b0) begin
                errors++;
                $display("FAIL done_width: CS_done=%0b one cycle after pulse, required 0", CS_done);
            end
        end
        @(posedge CLOCK_50_I); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLOCK_50_I);
        #1;
        checks++;
        if (CS_done !== 1'b0 || S_write_enable !== 1'b0 || S_write_data !== 32'sd0 ||
            S_write_address !== 7'd0 || T_read_address !== 7'd0) begin
            errors++;
            $display("FAIL reset_state: done=%0b we=%0b data=%0d waddr=%0d taddr=%0d, required all 0",
                     CS_done, S_write_enable, S_write_data, S_write_address, T_read_address);
        end
        Resetn = 1'b1;
        repeat (2) @(posedge CLOCK_50_I);
        #1;
        checks++;
        if (S_write_enable !== 1'b0 || CS_done !== 1'b0 || T_read_address !== 7'd0) begin
            errors++;
            $display("FAIL idle_state: we=%0b done=%0b taddr=%0d, required 0", S_write_enable, CS_done, T_read_address);
        end
    endtask

    task automatic test_zero();
        clear_t();
        run_blocks(1, 1'b0, -1, -1);
    endtask

    task automatic test_dc();
        clear_t();
        tmem[0] = 32'sd4096;
        run_blocks(1, 1'b0, -1, -1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (smem[i*8] !== 32'sd23168) begin
                errors++;
                $display("FAIL dc_S%0d0: got %0d, required 23168", i, smem[i*8]);
            end
        end
    endtask

    task automatic test_col();
        clear_t();
        tmem[8+2] = 32'sd256;
        run_blocks(1, 1'b0, -1, -1);
        checks++;
        if (smem[2] !== 32'sd2008 || smem[26] !== 32'sd399 || smem[58] !== -32'sd2008) begin
            errors++;
            $display("FAIL col_spot: S02=%0d S32=%0d S72=%0d, required 2008 399 -2008", smem[2], smem[26], smem[58]);
        end
    endtask

    task automatic test_round();
        clear_t();
        tmem[0] = 32'sd1;
        run_blocks(1, 1'b0, -1, -1);
        checks++;
        if (smem[0] !== 32'(ONE_EXP)) begin
            errors++;
            $display("FAIL round_pos: S00=%0d, required %0d", smem[0], ONE_EXP);
        end
        tmem[0] = -32'sd1;
        run_blocks(1, 1'b0, -1, -1);
        checks++;
        if (smem[0] !== -32'sd6) begin
            errors++;
            $display("FAIL round_neg: S00=%0d, required -6", smem[0]);
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 64; a++) tmem[a] = 32'($urandom_range(0, 2097151)) - 32'sd1048576;
        run_blocks(1, 1'b0, -1, -1);
        for (int a = 0; a < 64; a++) tmem[a] = 32'($urandom);
        run_blocks(1, 1'b0, -1, -1);
    endtask

    task automatic test_reset_mid();
        int nw;
        for (int a = 0; a < 64; a++) tmem[a] = 32'($urandom_range(0, 65535)) - 32'sd32768;
        run_blocks(1, 1'b0, -1, 200);
        repeat (2) @(posedge CLOCK_50_I);
        #1;
        Resetn = 1'b1;
        nw = 0;
        repeat (600) begin
            @(negedge CLOCK_50_I);
            if (S_write_enable || CS_done) nw++;
        end
        checks++;
        if (nw != 0) begin
            errors++;
            $display("FAIL reset_quiet: %0d write/done cycles after reset, required 0", nw);
        end
        @(posedge CLOCK_50_I); #1;
        run_blocks(1, 1'b0, 100, -1);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 64; a++) tmem[a] = 32'($urandom_range(0, 8191)) - 32'sd4096;
        run_blocks(2, 1'b1, -1, -1);
    endtask

    initial begin
        clear_t();
        test_reset();
        test_zero();
        test_dc();
        test_col();
        test_round();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
